uart_rx_packetizer: RTL and testbench

UART_RX_PACKETIZER -- requirements
Module: uart_rx_packetizer

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_defs.vh | 8 +
 rtl/uart_idle_timer.sv | 40 ++++
 rtl/uart_rx_packetizer.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_packetizer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and packet layout for the UART packetizer.
// Optional checksum byte enabled by defining UART_PKT_CHECKSUM_EN.
`include "uart_defs.vh"

package uart_pkg;

  typedef enum logic [1:0] {
    e_reset,
    e_idle,
    e_collect,
    e_commit
  } state_e;

  // Byte offsets within an assembled packet.
  localparam int unsigned OPCODE_IDX = 0;
  localparam int unsigned ADDR_IDX   = 1;
  localparam int unsigned DATA_IDX   = 5;
  localparam int unsigned CSUM_IDX   = 9;

`ifdef UART_PKT_CHECKSUM_EN
  localparam int unsigned PKT_LEN = CSUM_IDX + 1;
`else
  localparam int unsigned PKT_LEN = CSUM_IDX;
`endif

  localparam int unsigned CNT_W = `SAFE_CLOG2(PKT_LEN + 1);

  typedef logic [PKT_LEN-1:0][7:0] pkt_buf_t;

`ifdef UART_PKT_CHECKSUM_EN
  // XOR of every byte that precedes the checksum byte.
  function automatic logic [7:0] pkt_xor(input pkt_buf_t p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < int'(CSUM_IDX); i++) begin
      x = x ^ p[i];
    end
    return x;
  endfunction
`endif

endpackage

// File: rtl/uart_defs.vh
// Shared preprocessor helpers for the UART receive path.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH

// $clog2 that never yields a zero-width vector.
`define SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

`endif

// File: rtl/uart_idle_timer.sv
// Saturating idle-gap timer; expired_o is high while the count sits at the last allowed value.
`include "uart_defs.vh"

module uart_idle_timer #(
  parameter int unsigned timeout_cycles_p = 208320
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TimerW = `SAFE_CLOG2(timeout_cycles_p + 1);
  localparam logic [TimerW-1:0] LastCount = TimerW'(timeout_cycles_p - 1);

  logic [TimerW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LastCount)) begin
      count_d = count_q + TimerW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/uart_rx_packetizer.sv
// Assembles received UART bytes into opcode/addr/data packets with a ready/valid output.
// Define UART_PKT_CHECKSUM_EN to append and verify an XOR checksum byte.
module uart_rx_packetizer
  import uart_pkg::*;
#(
  parameter int unsigned timeout_cycles_p = 208320
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_v_i,
  input  logic [7:0]  rx_i,
  output logic        pkt_v_o,
  input  logic        pkt_ready_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        timeout_o,
  output logic        overrun_o,
  output logic        csum_err_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  pkt_buf_t          pkt_buf_q, pkt_buf_d;
  logic              pkt_v_q, pkt_v_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              drop_csum;
  logic              timer_clear, timer_en, timer_expired;

  uart_idle_timer #(
    .timeout_cycles_p(timeout_cycles_p)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (timer_clear),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

`ifdef UART_PKT_CHECKSUM_EN
  logic csum_err_q, csum_err_d;
`endif

  // Next-state, byte capture, commit decision and error pulses.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pkt_buf_d   = pkt_buf_q;
    pkt_v_d     = pkt_v_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    drop_csum   = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    csum_err_d  = 1'b0;
`endif

    // Consumer handshake retires the held packet; a commit below may reload it.
    if (pkt_v_q && pkt_ready_i) begin
      pkt_v_d = 1'b0;
    end

    unique case (state_q)
      e_reset: begin
        state_d = e_idle;
      end

      e_idle: begin
        if (rx_v_i) begin
          pkt_buf_d[OPCODE_IDX] = rx_i;
          count_d               = CNT_W'(1);
          state_d               = e_collect;
        end
      end

      e_collect: begin
        timer_clear = rx_v_i;
        if (rx_v_i) begin
          // A byte on the expiry cycle still counts, so rx_v_i is checked first.
          pkt_buf_d[count_q] = rx_i;
          count_d            = count_q + CNT_W'(1);
          if (count_q == CNT_W'(PKT_LEN - 1)) begin
            state_d = e_commit;
          end
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          count_d   = '0;
          state_d   = e_idle;
        end else begin
          timer_en = 1'b1;
        end
      end

      e_commit: begin
        count_d = '0;
        state_d = e_idle;
        // Bytes cannot be accepted while committing.
        if (rx_v_i) begin
          overrun_d = 1'b1;
        end
`ifdef UART_PKT_CHECKSUM_EN
        drop_csum  = (pkt_xor(pkt_buf_q) != pkt_buf_q[CSUM_IDX]);
        csum_err_d = drop_csum;
`endif
        if (!drop_csum) begin
          if (!pkt_v_q || pkt_ready_i) begin
            pkt_v_d  = 1'b1;
            opcode_d = pkt_buf_q[OPCODE_IDX];
            addr_d   = pkt_buf_q[ADDR_IDX +: 4];
            data_d   = pkt_buf_q[DATA_IDX +: 4];
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = e_reset;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      count_q    <= '0;
      pkt_buf_q  <= '0;
      pkt_v_q    <= 1'b0;
      opcode_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pkt_buf_q  <= pkt_buf_d;
      pkt_v_q    <= pkt_v_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
`ifdef UART_PKT_CHECKSUM_EN
      csum_err_q <= csum_err_d;
`endif
    end
  end

  assign pkt_v_o   = pkt_v_q;
  assign opcode_o  = opcode_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign timeout_o = timeout_q;
  assign overrun_o = overrun_q;
`ifdef UART_PKT_CHECKSUM_EN
  assign csum_err_o = csum_err_q;
`else
  assign csum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Self-checking bench for uart_rx_packetizer: directed scenarios plus a randomized byte stream
// checked against a stream-level reference model.
module tb_uart_rx_packetizer;

  localparam int unsigned TIMEOUT = 128;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int PLEN = 10;
`else
  localparam int PLEN = 9;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        rx_v_i;
  logic [7:0]  rx_i;
  logic        pkt_v_o;
  logic        pkt_ready_i;
  logic [7:0]  opcode_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic        timeout_o;
  logic        overrun_o;
  logic        csum_err_o;

  uart_rx_packetizer #(
    .timeout_cycles_p(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_v_i     (rx_v_i),
    .rx_i       (rx_i),
    .pkt_v_o    (pkt_v_o),
    .pkt_ready_i(pkt_ready_i),
    .opcode_o   (opcode_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .timeout_o  (timeout_o),
    .overrun_o  (overrun_o),
    .csum_err_o (csum_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int n_timeout = 0;
  int n_overrun = 0;
  int n_csum = 0;
  logic [71:0] got_q [$];
  logic [7:0]  pk [PLEN];

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor between edges: count error pulse cycles, log every accepted packet.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (timeout_o) n_timeout++;
      if (overrun_o) n_overrun++;
      if (csum_err_o) n_csum++;
      if (pkt_v_o && pkt_ready_i) got_q.push_back({opcode_o, addr_o, data_o});
    end
  end

  function automatic logic [71:0] fields_of(input logic [7:0] b [PLEN]);
    return {b[0], b[4], b[3], b[2], b[1], b[8], b[7], b[6], b[5]};
  endfunction

  function automatic logic [7:0] xor9(input logic [7:0] b [PLEN]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 9; i++) x = x ^ b[i];
    return x;
  endfunction

  function automatic logic [71:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 72'hx;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // gap idle cycles, then a one-cycle byte strobe.
  task automatic send_byte(input int gap, input logic [7:0] b);
    repeat (gap) tick();
    rx_v_i = 1'b1;
    rx_i   = b;
    tick();
    rx_v_i = 1'b0;
    rx_i   = 8'($urandom);
  endtask

  task automatic set_csum();
`ifdef UART_PKT_CHECKSUM_EN
    pk[9] = xor9(pk);
`endif
  endtask

  task automatic rand_pkt();
    for (int i = 0; i < PLEN; i++) pk[i] = 8'($urandom);
    set_csum();
  endtask

  task automatic send_pkt(input int first_gap, input int gap);
    for (int i = 0; i < PLEN; i++) send_byte((i == 0) ? first_gap : gap, pk[i]);
  endtask

  // Random byte stream; the model works purely on (gap, byte) pairs.
  task automatic run_random(input int n_pkts);
    int          gap_q [$];
    logic [7:0]  byte_q [$];
    logic [71:0] exp_q [$];
    logic [7:0]  cur [PLEN];
    int          cnt, e_t, e_o, e_c, b_t, b_o, b_c, g, n, r;
    bit          last_done, prev_partial, full;
    prev_partial = 1'b0;
    for (int p = 0; p < n_pkts; p++) begin
      full = ($urandom_range(0, 4) != 0);
      n    = full ? PLEN : int'($urandom_range(1, PLEN - 1));
      rand_pkt();
`ifdef UART_PKT_CHECKSUM_EN
      if (full && $urandom_range(0, 5) == 0) pk[9] = pk[9] ^ 8'($urandom_range(1, 255));
`endif
      for (int i = 0; i < n; i++) begin
        if (i == 0) begin
          g = prev_partial ? int'(TIMEOUT + $urandom_range(0, 3)) : int'($urandom_range(1, 6));
        end else begin
          r = int'($urandom_range(0, 19));
          g = (r == 0) ? int'(TIMEOUT - 1) : (r == 1) ? int'(TIMEOUT) :
              int'($urandom_range(0, 4));
        end
        gap_q.push_back(g);
        byte_q.push_back(pk[i]);
      end
      prev_partial = !full;
    end

    cnt = 0; e_t = 0; e_o = 0; e_c = 0; last_done = 1'b0;
    for (int k = 0; k < gap_q.size(); k++) begin
      if (last_done && gap_q[k] == 0) begin
        e_o++;
        last_done = 1'b0;
        continue;
      end
      last_done = 1'b0;
      if (cnt > 0 && gap_q[k] >= int'(TIMEOUT)) begin
        e_t++;
        cnt = 0;
      end
      cur[cnt] = byte_q[k];
      cnt++;
      if (cnt == PLEN) begin
        cnt = 0;
        last_done = 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
        if (cur[9] != xor9(cur)) e_c++;
        else exp_q.push_back(fields_of(cur));
`else
        exp_q.push_back(fields_of(cur));
`endif
      end
    end
    if (cnt > 0) e_t++;

    b_t = n_timeout; b_o = n_overrun; b_c = n_csum;
    got_q.delete();
    for (int k = 0; k < gap_q.size(); k++) send_byte(gap_q[k], byte_q[k]);
    repeat (TIMEOUT + 8) tick();

    check_eq("rnd_pkt_count", 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) check_eq("rnd_pkt", got_at(i), exp_q[i]);
    check_eq("rnd_timeouts", 72'(n_timeout - b_t), 72'(e_t));
    check_eq("rnd_overruns", 72'(n_overrun - b_o), 72'(e_o));
    check_eq("rnd_csum_errs", 72'(n_csum - b_c), 72'(e_c));
  endtask

  logic [7:0]  s1 [9];
  logic [71:0] fa, fb, fc;
  int          b_t, b_o, b_c;

  initial begin
    reset_i     = 1'b1;
    rx_v_i      = 1'b0;
    rx_i        = 8'h00;
    pkt_ready_i = 1'b0;
    repeat (3) tick();
    check_eq("rst_pkt_v", 72'(pkt_v_o), 72'(0));
    check_eq("rst_opcode", 72'(opcode_o), 72'(0));
    check_eq("rst_addr", 72'(addr_o), 72'(0));
    check_eq("rst_data", 72'(data_o), 72'(0));
    check_eq("rst_timeout", 72'(timeout_o), 72'(0));
    check_eq("rst_overrun", 72'(overrun_o), 72'(0));
    check_eq("rst_csum_err", 72'(csum_err_o), 72'(0));
    reset_i = 1'b0;
    repeat (3) tick();

    // Directed packet, bytes 100 cycles apart, consumer always ready.
    s1 = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 9; i++) pk[i] = s1[i];
    set_csum();
    pkt_ready_i = 1'b1;
    b_t = n_timeout; b_o = n_overrun; b_c = n_csum;
    got_q.delete();
    for (int i = 0; i < PLEN; i++) send_byte(99, pk[i]);
    check_eq("lat_commit_cycle", 72'(pkt_v_o), 72'(0));
    tick();
    check_eq("lat_two_cycles", 72'(pkt_v_o), 72'(1));
    check_eq("s1_opcode", 72'(opcode_o), 72'(8'h01));
    check_eq("s1_addr", 72'(addr_o), 72'(32'h1234_5678));
    check_eq("s1_data", 72'(data_o), 72'(32'hDEAD_BEEF));
    tick();
    check_eq("s1_accepted", 72'(got_q.size()), 72'(1));
    check_eq("s1_cleared", 72'(pkt_v_o), 72'(0));
    check_eq("s1_no_errors", 72'(n_timeout - b_t + n_overrun - b_o + n_csum - b_c), 72'(0));

    // Partial packet followed by silence.
    b_t = n_timeout;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_byte(2, 8'($urandom));
    repeat (TIMEOUT + 5) tick();
    check_eq("to_pulse_once", 72'(n_timeout - b_t), 72'(1));
    check_eq("to_no_pkt", 72'(got_q.size()), 72'(0));
    rand_pkt();
    fa = fields_of(pk);
    send_pkt(2, 3);
    repeat (4) tick();
    check_eq("to_next_pkt", got_at(0), fa);

    // Consumer stalled across two packets: second is dropped.
    pkt_ready_i = 1'b0;
    b_o = n_overrun;
    got_q.delete();
    rand_pkt();
    fa = fields_of(pk);
    send_pkt(3, 1);
    repeat (4) tick();
    check_eq("ov_first_valid", 72'(pkt_v_o), 72'(1));
    rand_pkt();
    send_pkt(3, 1);
    repeat (5) tick();
    check_eq("ov_held_v", 72'(pkt_v_o), 72'(1));
    check_eq("ov_held_fields", {opcode_o, addr_o, data_o}, fa);
    check_eq("ov_pulse_once", 72'(n_overrun - b_o), 72'(1));
    check_eq("ov_none_taken", 72'(got_q.size()), 72'(0));
    pkt_ready_i = 1'b1;
    repeat (2) tick();
    check_eq("ov_drain_count", 72'(got_q.size()), 72'(1));
    check_eq("ov_drain_pkt", got_at(0), fa);
    check_eq("ov_drained", 72'(pkt_v_o), 72'(0));

    // Byte arriving in the commit cycle is discarded.
    b_o = n_overrun; b_t = n_timeout;
    got_q.delete();
    rand_pkt();
    fc = fields_of(pk);
    send_pkt(3, 2);
    send_byte(0, 8'($urandom));
    repeat (5) tick();
    check_eq("cc_overrun", 72'(n_overrun - b_o), 72'(1));
    check_eq("cc_pkt_count", 72'(got_q.size()), 72'(1));
    check_eq("cc_pkt", got_at(0), fc);
    check_eq("cc_no_timeout", 72'(n_timeout - b_t), 72'(0));

    // Ready rises exactly in the second packet's commit cycle.
    pkt_ready_i = 1'b0;
    b_o = n_overrun;
    got_q.delete();
    rand_pkt();
    fa = fields_of(pk);
    send_pkt(3, 1);
    repeat (4) tick();
    rand_pkt();
    fb = fields_of(pk);
    send_pkt(3, 2);
    pkt_ready_i = 1'b1;
    tick();
    check_eq("rc_reload_v", 72'(pkt_v_o), 72'(1));
    check_eq("rc_reload_fields", {opcode_o, addr_o, data_o}, fb);
    tick();
    check_eq("rc_count", 72'(got_q.size()), 72'(2));
    check_eq("rc_first", got_at(0), fa);
    check_eq("rc_second", got_at(1), fb);
    check_eq("rc_no_overrun", 72'(n_overrun - b_o), 72'(0));

    // Reset mid-packet with a packet held on the outputs.
    pkt_ready_i = 1'b0;
    rand_pkt();
    send_pkt(3, 1);
    repeat (4) tick();
    rand_pkt();
    for (int i = 0; i < 4; i++) send_byte(2, pk[i]);
    b_t = n_timeout; b_o = n_overrun; b_c = n_csum;
    tick();
    reset_i = 1'b1;
    repeat (2) tick();
    check_eq("mr_pkt_v", 72'(pkt_v_o), 72'(0));
    check_eq("mr_fields", {opcode_o, addr_o, data_o}, 72'(0));
    check_eq("mr_pulses", 72'({timeout_o, overrun_o, csum_err_o}), 72'(0));
    reset_i = 1'b0;
    repeat (4) tick();
    check_eq("mr_no_errors", 72'(n_timeout - b_t + n_overrun - b_o + n_csum - b_c), 72'(0));
    check_eq("mr_still_empty", 72'(pkt_v_o), 72'(0));
    pkt_ready_i = 1'b1;
    got_q.delete();
    rand_pkt();
    fc = fields_of(pk);
    send_pkt(2, 1);
    repeat (4) tick();
    check_eq("mr_next_count", 72'(got_q.size()), 72'(1));
    check_eq("mr_next_pkt", got_at(0), fc);

`ifdef UART_PKT_CHECKSUM_EN
    // Wrong checksum drops the packet; correct one delivers it.
    b_c = n_csum;
    got_q.delete();
    rand_pkt();
    pk[9] = pk[9] ^ 8'h5A;
    send_pkt(3, 1);
    repeat (4) tick();
    check_eq("cs_err_once", 72'(n_csum - b_c), 72'(1));
    check_eq("cs_no_pkt", 72'(got_q.size()), 72'(0));
    check_eq("cs_v_low", 72'(pkt_v_o), 72'(0));
    set_csum();
    fa = fields_of(pk);
    send_pkt(3, 1);
    repeat (4) tick();
    check_eq("cs_good_pkt", got_at(0), fa);
    check_eq("cs_no_new_err", 72'(n_csum - b_c), 72'(1));
`endif

    run_random(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
